// File: rtl/pipe_reg_chain.sv
// Valid/ready register pipeline with per-stage valids, bubble collapse, synchronous flush
// and an occupancy count.
module pipe_reg_chain #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH-1:0] rdy;

    // A stage can take new data if it is empty or its own content moves on this cycle.
    always_comb begin : ready_chain
        logic r;
        r = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r      = !v_q[k] || r;
            rdy[k] = r;
        end
    end

    assign in_ready = rdy[0] && !flush;

    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = d_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = v_q[k];
            d_d[k] = d_q[k];
            if (rdy[k]) begin
                v_d[k] = up_v[k];
                if (up_v[k]) begin
                    d_d[k] = up_d[k];
                end
            end
        end
    end

    // Flush clears valids only; data registers keep their contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RESET_VALUE;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + CntW'(v_q[k]);
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

endmodule
